// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with a
// variable-latency memory handshake, wait timeout, halt and retired count.
module mc_control_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic             inst20,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             ALUjump,
    output logic             PCplus4toReg,
    output logic             AddertoReg,
    output logic [1:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_R, C_I, C_LOAD, C_STORE, C_BRANCH,
        C_JALR, C_JAL, C_AUIPC, C_LUI, C_SYSTEM, C_FENCE
    } cls_t;

    state_t            state_q, state_d;
    cls_t              cls_q, dec_cls, sel_cls;
    logic              inst20_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expire;
    logic              set_illegal, set_timeout;
    logic              sel_en;

    function automatic cls_t decode_op(input logic [4:0] op);
        case (op)
            5'b01100: return C_R;
            5'b00100: return C_I;
            5'b00000: return C_LOAD;
            5'b01000: return C_STORE;
            5'b11000: return C_BRANCH;
            5'b11001: return C_JALR;
            5'b11011: return C_JAL;
            5'b00101: return C_AUIPC;
            5'b01101: return C_LUI;
            5'b11100: return C_SYSTEM;
            5'b00011: return C_FENCE;
            default:  return C_ILLEGAL;
        endcase
    endfunction

    assign dec_cls     = decode_op(opcode);
    assign state       = state_q;
    // Fires on the last permitted wait cycle if ready is still low.
    assign wait_expire = TIMEOUT_EN && !mem_ready && (wait_cnt == WAIT_LAST);

    // Next-state and strobe decode
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        halted      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_expire) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_DECODE: begin
                if (dec_cls == C_ILLEGAL) begin
                    set_illegal = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH, C_FENCE: begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_SYSTEM: begin
                        if (inst20_q) begin
                            state_d = S_HALT;
                        end else begin
                            pc_write = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                MemRead  = (cls_q == C_LOAD);
                MemWrite = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (wait_expire) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_WB: begin
                RegWrite = cls_q inside {C_R, C_I, C_LOAD, C_JAL, C_JALR, C_AUIPC, C_LUI};
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_BOOT;
        endcase
    end

    // Datapath selects; DECODE uses the live IR opcode since the class latches at its end
    always_comb begin
        sel_cls      = (state_q == S_DECODE) ? dec_cls : cls_q;
        sel_en       = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB};
        ALUOp        = 2'b00;
        ALUSrc       = 1'b0;
        MemtoReg     = 1'b0;
        branch       = 1'b0;
        ALUjump      = 1'b0;
        PCplus4toReg = 1'b0;
        AddertoReg   = 1'b0;
        if (sel_en) begin
            case (sel_cls)
                C_R, C_I: ALUOp = 2'b10;
                C_BRANCH: ALUOp = 2'b01;
                C_LUI:    ALUOp = 2'b11;
                default:  ALUOp = 2'b00;
            endcase
            ALUSrc       = sel_cls inside {C_I, C_LOAD, C_STORE, C_JALR, C_LUI};
            MemtoReg     = (sel_cls == C_LOAD);
            branch       = sel_cls inside {C_BRANCH, C_JAL};
            ALUjump      = (sel_cls == C_JALR);
            PCplus4toReg = sel_cls inside {C_JAL, C_JALR};
            AddertoReg   = (sel_cls == C_AUIPC);
        end
    end

    // State, latched class, wait counter, sticky flags and retired count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_BOOT;
            cls_q    <= C_ILLEGAL;
            inst20_q <= 1'b0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
            instret  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q    <= dec_cls;
                inst20_q <= inst20;
            end
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (TIMEOUT_EN && mem_req && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (set_illegal) illegal <= 1'b1;
            if (set_timeout) timeout <= 1'b1;
            if (pc_write) instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus randomized instruction
// streams checked against per-instruction cycle/strobe expectations.
module tb_mc_control_fsm;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    localparam logic [4:0] OP_FENCE  = 5'b00011;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    opcode = 5'b0;
    logic          inst20 = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, ir_write, pc_write, branch, ALUSrc, MemtoReg;
    logic          ALUjump, PCplus4toReg, AddertoReg;
    logic [1:0]    ALUOp;
    logic          MemRead, MemWrite, RegWrite, halted, illegal, timeout;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    logic [16:0]   ctl;
    logic [7:0]    sel;
    int            checks = 0;
    int            failures = 0;
    int            exp_ret = 0;

    mc_control_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .inst20(inst20), .mem_ready(mem_ready),
        .mem_req(mem_req), .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ALUjump(ALUjump),
        .PCplus4toReg(PCplus4toReg), .AddertoReg(AddertoReg), .ALUOp(ALUOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .halted(halted),
        .illegal(illegal), .timeout(timeout), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, ir_write, pc_write, branch, ALUSrc, MemtoReg, ALUjump, PCplus4toReg,
                  AddertoReg, ALUOp, MemRead, MemWrite, RegWrite, halted, illegal, timeout};
    assign sel = {ALUOp, ALUSrc, MemtoReg, branch, ALUjump, PCplus4toReg, AddertoReg};

    // {ALUOp, ALUSrc, MemtoReg, branch, ALUjump, PCplus4toReg, AddertoReg} per opcode class
    function automatic logic [7:0] exp_sel(input logic [4:0] op);
        case (op)
            OP_R:      return 8'b10_000000;
            OP_I:      return 8'b10_100000;
            OP_LOAD:   return 8'b00_110000;
            OP_STORE:  return 8'b00_100000;
            OP_BRANCH: return 8'b01_001000;
            OP_JALR:   return 8'b00_100110;
            OP_JAL:    return 8'b00_001010;
            OP_AUIPC:  return 8'b00_000001;
            OP_LUI:    return 8'b11_100000;
            default:   return 8'b00_000000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL,
                          OP_AUIPC, OP_LUI, OP_SYSTEM, OP_FENCE};
    endfunction

    function automatic bit writes_reg(input logic [4:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== 17'h0 || state !== 3'd0 || instret !== CW'(0)) begin
            failures++;
            $display("FAIL reset_outputs: ctl=%h state=%0d instret=%0d expected all 0", ctl, state, instret);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_req: state=%0d mem_req=%0d expected 1/1", state, mem_req);
        end
    endtask

    // Runs one instruction from FETCH with a reactive memory; checks counts against the class rules
    task automatic run_instr(input logic [4:0] op, input logic i20, input int fw, input int mw);
        int cyc = 0, rw = 0, mr = 0, mwc = 0, pcw = 0, acc = 0, waited = 0, it = 0;
        int pc_state = -1;
        bit done = 0;
        bit ill, ebrk, shrt, ld, st, halts;
        int exp_cyc, exp_pcst;
        ill   = !is_legal(op);
        ebrk  = (op == OP_SYSTEM) && i20;
        shrt  = (op == OP_BRANCH) || (op == OP_FENCE) || ((op == OP_SYSTEM) && !i20);
        ld    = (op == OP_LOAD);
        st    = (op == OP_STORE);
        halts = ill || ebrk;
        if (ill)            exp_cyc = 2 + fw;
        else if (ebrk || shrt) exp_cyc = 3 + fw;
        else if (ld)        exp_cyc = 5 + fw + mw;
        else if (st)        exp_cyc = 4 + fw + mw;
        else                exp_cyc = 4 + fw;
        exp_pcst = shrt ? 3 : (st ? 4 : 5);
        opcode = op;
        inst20 = i20;
        while (!done && it < 60) begin
            it++;
            if (mem_req) begin
                if (waited < ((acc == 0) ? fw : mw)) begin
                    mem_ready = 1'b0;
                    waited++;
                end else begin
                    mem_ready = 1'b1;
                    waited = 0;
                    acc++;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (state === 3'd6) begin
                done = 1;
            end else begin
                cyc++;
                rw  += int'(RegWrite);
                mr  += int'(MemRead);
                mwc += int'(MemWrite);
                pcw += int'(pc_write);
                if (state inside {3'd2, 3'd3, 3'd4, 3'd5}) begin
                    checks++;
                    if (sel !== exp_sel(op)) begin
                        failures++;
                        $display("FAIL selects op=%b state=%0d: got %b expected %b", op, state, sel, exp_sel(op));
                    end
                end
                if (pc_write === 1'b1) begin
                    pc_state = int'(state);
                    done = 1;
                end
            end
            @(negedge clk);
        end
        if (!halts) exp_ret++;
        checks++;
        if (cyc != exp_cyc) begin
            failures++;
            $display("FAIL cycles op=%b fw=%0d mw=%0d: got %0d expected %0d", op, fw, mw, cyc, exp_cyc);
        end
        checks++;
        if (rw != ((writes_reg(op) && !halts) ? 1 : 0) || mr != (ld ? 1 + mw : 0) || mwc != (st ? 1 + mw : 0)) begin
            failures++;
            $display("FAIL strobes op=%b: regwrite=%0d memread=%0d memwrite=%0d", op, rw, mr, mwc);
        end
        checks++;
        if (pcw != (halts ? 0 : 1) || (!halts && pc_state != exp_pcst)) begin
            failures++;
            $display("FAIL pc_write op=%b: count=%0d in state %0d expected %0d in state %0d",
                     op, pcw, pc_state, halts ? 0 : 1, exp_pcst);
        end
        checks++;
        if (instret !== CW'(exp_ret)) begin
            failures++;
            $display("FAIL instret op=%b: got %0d expected %0d", op, instret, CW'(exp_ret));
        end
        checks++;
        if (state !== (halts ? 3'd6 : 3'd1) || halted !== halts || illegal !== ill || timeout !== 1'b0) begin
            failures++;
            $display("FAIL end_state op=%b: state=%0d halted=%0d illegal=%0d timeout=%0d", op, state, halted, illegal, timeout);
        end
    endtask

    task automatic test_add_sequence();
        int exp_st[6];
        exp_st = '{0, 1, 2, 3, 5, 1};
        @(negedge clk);
        rst = 1'b1;
        opcode = OP_R;
        inst20 = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state !== 3'(exp_st[i]) || RegWrite !== (exp_st[i] == 5) || pc_write !== (exp_st[i] == 5)) begin
                failures++;
                $display("FAIL add_seq cycle %0d: state=%0d regwrite=%0d pc_write=%0d expected state %0d",
                         i, state, RegWrite, pc_write, exp_st[i]);
            end
            if (exp_st[i] >= 2) begin
                checks++;
                if (ALUOp !== 2'b10) begin
                    failures++;
                    $display("FAIL add_aluop cycle %0d: got %b expected 10", i, ALUOp);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== CW'(1)) begin
            failures++;
            $display("FAIL add_instret: got %0d expected 1", instret);
        end
    endtask

    task automatic test_load_wait();
        do_reset();
        run_instr(OP_LOAD, 1'b0, 0, 2);
    endtask

    task automatic test_branch_store();
        do_reset();
        run_instr(OP_BRANCH, 1'b0, 0, 0);
        run_instr(OP_STORE, 1'b0, 0, 0);
        run_instr(OP_SYSTEM, 1'b0, 1, 0);
    endtask

    task automatic test_random();
        logic [4:0] ops[11];
        logic [4:0] op;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL, OP_AUIPC, OP_LUI, OP_SYSTEM, OP_FENCE};
        do_reset();
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 10)];
            run_instr(op, (op == OP_SYSTEM) ? 1'b0 : 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 16; n++) run_instr(OP_FENCE, 1'b0, 0, 0);
        checks++;
        if (instret !== CW'(0)) begin
            failures++;
            $display("FAIL wrap: got %0d expected 0", instret);
        end
    endtask

    task automatic test_ebreak();
        do_reset();
        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_SYSTEM, 1'b1, int'($urandom_range(0, TO - 1)), 0);
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (mem_req !== 1'b0 || state !== 3'd6 || halted !== 1'b1 || instret !== CW'(1)) begin
                failures++;
                $display("FAIL ebreak_hold: mem_req=%0d state=%0d halted=%0d instret=%0d", mem_req, state, halted, instret);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [4:0] op;
        do_reset();
        run_instr(5'b11111, 1'b0, 0, 0);
        op = 5'b11111;
        for (int t = 0; t < 100; t++) begin
            op = 5'($urandom_range(0, 31));
            if (!is_legal(op)) break;
        end
        do_reset();
        run_instr(op, 1'b0, int'($urandom_range(0, TO - 1)), 0);
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = OP_R;
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b0;
            #1;
            checks++;
            if (state !== 3'd1 || mem_req !== 1'b1) begin
                failures++;
                $display("FAIL timeout_wait %0d: state=%0d mem_req=%0d expected 1/1", k, state, mem_req);
            end
            @(negedge clk);
        end
        checks++;
        if (state !== 3'd6 || timeout !== 1'b1 || halted !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fire: state=%0d timeout=%0d halted=%0d expected 6/1/1", state, timeout, halted);
        end
        do_reset();
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b0;
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ir_write !== 1'b1) begin
            failures++;
            $display("FAIL timeout_edge_irw: got %0d expected 1", ir_write);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd2 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_edge: state=%0d timeout=%0d expected 2/0", state, timeout);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        opcode = OP_LOAD;
        inst20 = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state !== 3'd4 || MemRead !== 1'b1) begin
            failures++;
            $display("FAIL mid_mem_setup: state=%0d memread=%0d expected 4/1", state, MemRead);
        end
        #2;
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== 17'h0 || state !== 3'd0 || instret !== CW'(0)) begin
            failures++;
            $display("FAIL async_reset: ctl=%h state=%0d instret=%0d expected all 0", ctl, state, instret);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_wins: state=%0d mem_req=%0d expected 0/0", state, mem_req);
        end
        rst = 1'b0;
        exp_ret = 0;
        @(negedge clk);
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL post_reset: state=%0d expected 1", state);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        test_add_sequence();
        test_load_wait();
        test_branch_store();
        test_random();
        test_wrap();
        test_ebreak();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

- Multi-cycle control unit for the RV32I core; successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Handshakes with a variable-latency memory, with a parametrised wait timeout.
- Halts on ebreak, illegal opcode or timeout, and counts retired instructions; sits between the instruction register and the datapath muxes/enables.

## Interface
- TIMEOUT_CYCLES, 16, max cycles waiting on mem_ready before halting; 0 disables timeout.
- CNT_W, 32, width of the retired-instruction counter.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  5  instruction bits [6:2] from the instruction register.
- inst20  in  1  instruction bit 20 (ecall=0 / ebreak=1).
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- mem_req  out  1  memory access request (FETCH and MEM states).
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC (final cycle of each instruction).
- branch, ALUSrc, MemtoReg, ALUjump, PCplus4toReg, AddertoReg  out  1 each  datapath selects.
- ALUOp  out  2  ALU operation class.
- MemRead, MemWrite, RegWrite  out  1 each  gated strobes.
- halted  out  1  sticky halt.
- illegal  out  1  sticky illegal-opcode flag.
- timeout  out  1  sticky timeout flag.
- state  out  3  current state.
- instret  out  CNT_W  retired-instruction count.

## Operation
- Opcode[6:2] classes:
  - R 01100, I 00100, LOAD 00000, STORE 01000, BRANCH 11000.
  - JALR 11001, JAL 11011, AUIPC 00101, LUI 01101, SYSTEM 11100, FENCE 00011.
  - Any other value is illegal.
- State encoding: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 unreachable and recovers to BOOT.
- BOOT: all outputs 0; always goes to FETCH.
- FETCH:
  - mem_req=1.
  - When mem_ready=1: ir_write=1 that cycle, go to DECODE.
  - Otherwise stay.
- DECODE:
  - Latch opcode class and inst20 into internal registers.
  - Illegal opcode: go to HALT and set illegal.
  - Otherwise go to EXEC.
- EXEC, next state by class:
  - LOAD/STORE: go to MEM.
  - BRANCH, FENCE, SYSTEM with inst20=0: pc_write=1, go to FETCH.
  - SYSTEM with inst20=1: go to HALT, no pc_write.
  - All others: go to WB.
- MEM:
  - mem_req=1; MemRead=1 for LOAD, MemWrite=1 for STORE.
  - On mem_ready: LOAD goes to WB; STORE asserts pc_write and goes to FETCH.
- WB:
  - RegWrite=1 for R, I, LOAD, JAL, JALR, AUIPC, LUI.
  - pc_write=1; go to FETCH.
- HALT: absorbing until rst; halted=1; all strobes 0.
- Latched-class selects are driven in DECODE..WB and are 0 in BOOT/FETCH/HALT:
  - ALUOp: R/I=10, BRANCH=01, LUI=11, otherwise 00.
  - ALUSrc=1: I, LOAD, STORE, JALR, LUI.
  - MemtoReg=1: LOAD.
  - branch=1: BRANCH, JAL.
  - ALUjump=1: JALR.
  - PCplus4toReg=1: JAL, JALR.
  - AddertoReg=1: AUIPC.
- Timeout:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 with mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES with ready still low: go to HALT and set timeout.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- instret increments by 1 in every cycle with pc_write=1 and wraps modulo 2^CNT_W.

## Timing
- Reset (async, any state, mid-access included):
  - state=BOOT, instret=0, illegal/timeout/halted=0, wait counter=0, all outputs 0.
  - The first mem_req appears one cycle after rst deasserts.
- All outputs are decoded from registered state/class; no combinational path from mem_ready to any output except ir_write and the MEM/FETCH-exit pc_write.
- Zero-wait memory (mem_ready high in the request cycle) cycle counts:
  - BRANCH/FENCE/ecall: 3.
  - R/I/LUI/AUIPC/JAL/JALR/STORE: 4.
  - LOAD: 5.
- Each wait cycle adds 1 to these counts.
- mem_ready=1 outside FETCH/MEM is ignored.
- mem_ready rising exactly on the TIMEOUT_CYCLES-th wait cycle completes the access; timeout does not fire.
- rst and mem_ready in the same cycle: reset wins.

## Test plan
- Reset release, mem_ready tied 1, opcode=01100 (add): states 0,1,2,3,5,1; RegWrite=1 only in WB, ALUOp=10, pc_write in WB; instret=1 after 5 cycles.
- LOAD (00000) with mem_ready low 2 cycles in MEM: MemRead=1 for 3 cycles, MemtoReg=1, RegWrite in WB, total 7 cycles.
- BRANCH (11000): pc_write in EXEC, branch=1, ALUOp=01, RegWrite never 1; STORE: MemWrite=1 in MEM, pc_write same cycle.
- SYSTEM with inst20=1: HALT after EXEC, halted=1, instret unchanged, no further mem_req; opcode=11111 gives HALT from DECODE with illegal=1.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH: after 4 wait cycles state=6, timeout=1; repeat with ready on cycle 4: no timeout.
- Assert rst mid-MEM: all outputs 0 immediately (async); CNT_W=4 with 16 NOPs (FENCE): instret wraps to 0.
